// File: rtl/cordic_seq_pkg.sv
// rtl/cordic_seq_pkg.sv - shared types and hyperbolic repeat helpers for the CORDIC iteration sequencer
package cordic_seq_pkg;

  typedef enum logic [1:0] {
    CIRC = 2'b00,
    LIN  = 2'b01,
    HYP  = 2'b10
  } coord_sys_e;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  // Enough 3k+1 terms to cover any shift field up to 27 bits without overflow.
  localparam int unsigned HYP_REP_TERMS = 16;

  function automatic logic is_hyp_repeat(input int unsigned shift, input int unsigned max_shift);
    int unsigned k;
    logic hit;
    k   = 4;
    hit = 1'b0;
    for (int i = 0; i < HYP_REP_TERMS; i++) begin
      if (k <= max_shift && k == shift) hit = 1'b1;
      k = 3 * k + 1;
    end
    return hit;
  endfunction

  function automatic int unsigned hyp_step_count(input int unsigned n_iter, input int unsigned max_shift);
    int unsigned k;
    int unsigned count;
    k     = 4;
    count = n_iter;
    for (int i = 0; i < HYP_REP_TERMS; i++) begin
      if (k <= max_shift && k <= n_iter) count = count + 1;
      k = 3 * k + 1;
    end
    return count;
  endfunction

endpackage

// File: rtl/cordic_iter_seq_timer.sv
// rtl/cordic_iter_seq_timer.sv - per-step phase counter producing the step strobe at the end of each window
module cordic_step_timer
  import cordic_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic step_en,
  output logic window_end
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(STEP_CYCLES - 1);

  logic [PW-1:0] phase_q;

  // Phase sits at zero whenever the sequencer is idle, so every run starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      phase_q <= '0;
    end else if (phase_q == LAST_PHASE) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_q + 1'b1;
    end
  end

  assign window_end = run && (phase_q == LAST_PHASE);
  assign step_en    = window_end;

endmodule

// File: rtl/cordic_iter_seq.sv
// rtl/cordic_iter_seq.sv - CORDIC iteration sequencer: shift schedule, step strobe and start/busy/done/abort handshake
module cordic_iter_seq
  import cordic_seq_pkg::*;
#(
  parameter int ITER_W      = 6,
  parameter int STEP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        coord_sys,
  input  logic [ITER_W-1:0] n_iter,
  output logic              busy,
  output logic              step_en,
  output logic [ITER_W-1:0] shift,
  output logic [ITER_W+1:0] iter_idx,
  output logic              repeat_flag,
  output logic              last,
  output logic              done
);

  localparam int CW = ITER_W + 2;
  localparam int unsigned MAX_SHIFT = (1 << ITER_W) - 1;

  seq_state_e        state_q, state_d;
  coord_sys_e        mode_q, mode_d;
  logic [CW-1:0]     total_q, total_d;
  logic [ITER_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     iter_q, iter_d;
  logic              rf_q, rf_d;
  logic              done_q, done_d;

  logic window_end;
  logic final_step;
  logic rep_hit;

  cordic_step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (busy),
    .step_en   (step_en),
    .window_end(window_end)
  );

  // The total step count is fixed at start, so "last" is just a compare against it.
  assign final_step = (iter_q == total_q - CW'(1));
  assign rep_hit    = is_hyp_repeat(32'(shift_q), MAX_SHIFT);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    total_d = total_q;
    shift_d = shift_q;
    iter_d  = iter_q;
    rf_d    = rf_q;
    done_d  = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          if (n_iter != '0) begin
            state_d = SEQ_RUN;
            mode_d  = coord_sys[1] ? HYP : coord_sys_e'(coord_sys);
            total_d = coord_sys[1] ? CW'(hyp_step_count(32'(n_iter), MAX_SHIFT)) : CW'(n_iter);
            shift_d = coord_sys[1] ? ITER_W'(1) : '0;
            iter_d  = '0;
            rf_d    = 1'b0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEQ_RUN: begin
        if (abort) begin
          state_d = SEQ_IDLE;
          rf_d    = 1'b0;
        end else if (window_end) begin
          iter_d = iter_q + CW'(1);
          if (final_step) begin
            state_d = SEQ_IDLE;
            done_d  = 1'b1;
            rf_d    = 1'b0;
          end else if (mode_q == HYP && rep_hit && !rf_q) begin
            rf_d = 1'b1;
          end else begin
            shift_d = shift_q + ITER_W'(1);
            rf_d    = 1'b0;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      mode_q  <= CIRC;
      total_q <= '0;
      shift_q <= '0;
      iter_q  <= '0;
      rf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      total_q <= total_d;
      shift_q <= shift_d;
      iter_q  <= iter_d;
      rf_q    <= rf_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == SEQ_RUN);
  assign shift       = shift_q;
  assign iter_idx    = iter_q;
  assign repeat_flag = rf_q;
  assign last        = busy && final_step;
  assign done        = done_q;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// tb/tb_cordic_iter_seq.sv - self-checking bench for cordic_iter_seq with a queue-based schedule model
module tb_cordic_iter_seq;

  localparam int IW = 6;
  localparam int OW = 2 * IW + 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst[2];
  logic          start[2];
  logic          abort[2];
  logic [1:0]    coord[2];
  logic [IW-1:0] n_iter[2];
  logic          busy[2];
  logic          step_en[2];
  logic [IW-1:0] shift[2];
  logic [IW+1:0] iter_idx[2];
  logic          repeat_flag[2];
  logic          last[2];
  logic          done[2];

  logic [IW-1:0] prev_shift[2];
  logic [IW+1:0] prev_iter[2];

  int tests = 0;
  int fails = 0;

  cordic_iter_seq #(.ITER_W(IW), .STEP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .coord_sys(coord[0]),
    .n_iter(n_iter[0]), .busy(busy[0]), .step_en(step_en[0]), .shift(shift[0]),
    .iter_idx(iter_idx[0]), .repeat_flag(repeat_flag[0]), .last(last[0]), .done(done[0])
  );

  cordic_iter_seq #(.ITER_W(IW), .STEP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .coord_sys(coord[1]),
    .n_iter(n_iter[1]), .busy(busy[1]), .step_en(step_en[1]), .shift(shift[1]),
    .iter_idx(iter_idx[1]), .repeat_flag(repeat_flag[1]), .last(last[1]), .done(done[1])
  );

  function automatic logic [OW-1:0] obs(input int d);
    return {busy[d], step_en[d], shift[d], iter_idx[d], repeat_flag[d], last[d], done[d]};
  endfunction

  function automatic logic [OW-1:0] mk(input bit b, input bit s, input logic [IW-1:0] sh,
                                       input logic [IW+1:0] it, input bit rf, input bit l, input bit dn);
    return {b, s, sh, it, rf, l, dn};
  endfunction

  function automatic bit is_rep(input int s);
    int k = 4;
    while (k <= s) begin
      if (k == s) return 1'b1;
      k = 3 * k + 1;
    end
    return 1'b0;
  endfunction

  task automatic check(input string tag, input int d, input logic [OW-1:0] e);
    logic [OW-1:0] o;
    o = obs(d);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s dut%0d got %h expected %h", tag, d, o, e);
    end
  endtask

  task automatic idle_check(input string tag, input int d);
    @(posedge clk); #1;
    check({tag, "/idle"}, d, mk(0, 0, prev_shift[d], prev_iter[d], 0, 0, 0));
  endtask

  // cut_kind: 0 none, 1 abort, 2 reset; applied in the first cycle of window cut_at.
  task automatic run(input int d, input logic [1:0] c, input int n, input int cut_kind,
                     input int cut_at, input bit hold, input string tag);
    int q_sh[$];
    bit q_rf[$];
    int sc;
    int total;
    if (c[1]) begin
      for (int s = 1; s <= n; s++) begin
        q_sh.push_back(s); q_rf.push_back(1'b0);
        if (is_rep(s)) begin q_sh.push_back(s); q_rf.push_back(1'b1); end
      end
    end else begin
      for (int s = 0; s < n; s++) begin q_sh.push_back(s); q_rf.push_back(1'b0); end
    end
    sc = (d == 0) ? 2 : 1;
    start[d] = 1'b1; coord[d] = c; n_iter[d] = IW'(n);
    @(posedge clk); #1;
    if (!hold) start[d] = 1'b0;
    coord[d] = 2'($urandom); n_iter[d] = IW'($urandom);
    if (n == 0) begin
      check({tag, "/n0done"}, d, mk(0, 0, prev_shift[d], prev_iter[d], 0, 0, 1));
      return;
    end
    total = q_sh.size();
    for (int t = 0; t < total * sc; t++) begin
      int w;
      w = t / sc;
      check($sformatf("%s/c%0d", tag, t), d,
            mk(1, (t % sc) == sc - 1, IW'(q_sh[w]), (IW+2)'(w), q_rf[w], w == total - 1, 0));
      if (cut_kind != 0 && t == cut_at * sc) begin
        if (cut_kind == 1) abort[d] = 1'b1; else rst[d] = 1'b1;
        @(posedge clk); #1;
        abort[d] = 1'b0; rst[d] = 1'b0; start[d] = 1'b0;
        if (cut_kind == 1) begin
          prev_shift[d] = IW'(q_sh[cut_at]); prev_iter[d] = (IW+2)'(cut_at);
        end else begin
          prev_shift[d] = '0; prev_iter[d] = '0;
        end
        check({tag, "/cut"}, d, mk(0, 0, prev_shift[d], prev_iter[d], 0, 0, 0));
        return;
      end
      @(posedge clk); #1;
    end
    prev_shift[d] = IW'(q_sh[total - 1]);
    prev_iter[d]  = (IW+2)'(total);
    check({tag, "/done"}, d, mk(0, 0, prev_shift[d], prev_iter[d], 0, 0, 1));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; abort[d] = 1'b0; coord[d] = 2'b00; n_iter[d] = '0;
      prev_shift[d] = '0; prev_iter[d] = '0;
    end
    @(posedge clk); @(posedge clk); #1;
    check("reset", 0, mk(0, 0, 0, 0, 0, 0, 0));
    check("reset", 1, mk(0, 0, 0, 0, 0, 0, 0));
    rst[0] = 1'b0; rst[1] = 1'b0;
    abort[0] = 1'b1;
    idle_check("abort_idle", 0);
    abort[0] = 1'b0;

    run(0, 2'b00, 4, 0, 0, 0, "circ4");   idle_check("circ4", 0);
    run(0, 2'b10, 5, 0, 0, 0, "hyp5");    idle_check("hyp5", 0);
    run(0, 2'b11, 13, 0, 0, 0, "hyp13");  idle_check("hyp13", 0);
    run(0, 2'b00, 8, 1, 2, 0, "abort8");  idle_check("abort8", 0);
    run(0, 2'b00, 8, 0, 0, 0, "rerun8");  idle_check("rerun8", 0);
    run(0, 2'b01, 3, 0, 0, 1, "hold3");
    run(0, 2'b00, 3, 0, 0, 0, "b2b3");    idle_check("b2b3", 0);
    run(0, 2'b00, 0, 0, 0, 0, "zero");    idle_check("zero", 0);
    run(1, 2'b10, 6, 0, 0, 0, "b_hyp6");  idle_check("b_hyp6", 1);
    run(1, 2'b00, 5, 2, 2, 0, "b_rst");   idle_check("b_rst", 1);
    run(1, 2'b01, 0, 0, 0, 0, "b_zero");  idle_check("b_zero", 1);

    for (int r = 0; r < 14; r++) begin
      int d;
      int n;
      logic [1:0] c;
      int cut;
      d = int'($urandom_range(0, 1));
      n = int'($urandom_range(0, 45));
      c = 2'($urandom);
      cut = 0;
      if (d == 0 && n >= 2 && $urandom_range(0, 2) == 0) cut = 1;
      run(d, c, n, cut, int'($urandom_range(1, n > 1 ? n - 1 : 1)), 0, $sformatf("rnd%0d", r));
      idle_check($sformatf("rnd%0d", r), d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cordic_iter_seq.md
Name: cordic_iter_seq

Overview:
Parametrised iteration sequencer for the CORDIC datapath; generates per-step shift amount, step strobe and run/done handshake for circular, linear and hyperbolic modes. Adds start/busy/done/abort handshake, runtime iteration count, configurable cycles-per-step cadence and general hyperbolic repeat handling (shifts 4, 13, 40, 121, ...). Sits between the CORDIC controller and the shift/add datapath plus atan/atanh ROM address.

Parameters:
ITER_W, 6, width of shift/iteration fields; max distinct shifts 2^ITER_W-1
STEP_CYCLES, 2, clock cycles per CORDIC step (>=1); datapath register latency budget

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request a run; accepted only when busy=0
abort  in  1  synchronous cancel of a run in progress
coord_sys  in  2  00 circular, 01 linear, 1x hyperbolic; sampled on accepted start
n_iter  in  ITER_W  number of distinct shift values; sampled on accepted start
busy  out  1  run in progress
step_en  out  1  one-cycle strobe: datapath executes step using current shift
shift  out  ITER_W  shift amount / ROM index for current step window
iter_idx  out  ITER_W+2  steps completed so far in this run
repeat_flag  out  1  current window is the repeated hyperbolic step
last  out  1  current window is the final step
done  out  1  one-cycle pulse after final step or n_iter==0

Behaviour:
- Reset: busy=0, step_en=0, done=0, shift=0, iter_idx=0, repeat_flag=0, last=0; state IDLE. Reset mid-run wins over everything, no done.
- States: IDLE, RUN. IDLE->RUN on start with n_iter!=0; IDLE stays IDLE on start with n_iter==0, done pulses next cycle. RUN->IDLE after final step window or on abort.
- Start at edge E: coord_sys/n_iter latched; from E busy=1, phase=0, iter_idx=0, shift = 0 (circular/linear) or 1 (hyperbolic).
- Each step window lasts STEP_CYCLES cycles; phase counts 0..STEP_CYCLES-1; step_en=1 only when phase==STEP_CYCLES-1 (STEP_CYCLES=1: step_en high every RUN cycle). shift, repeat_flag, last stable over whole window.
- At end of window: iter_idx+1. Circular/linear: shift+1. Hyperbolic: if shift is a repeat value (k=4, then k=3k+1: 4,13,40,121,...) and repeat_flag=0, hold shift and set repeat_flag=1; else shift+1, repeat_flag=0.
- Distinct-shift range: circular/linear 0..n_iter-1; hyperbolic 1..n_iter. Total steps = n_iter (+ number of repeat values <= n_iter in hyperbolic).
- last=1 in window where shift is final value and no repeat pending (hyperbolic: second pass of a repeat value if final shift is a repeat value).
- After final window: busy=0, done=1 for exactly one cycle, shift/iter_idx hold final values until next start.
- start while busy=1 ignored. start in the done cycle accepted (back-to-back).
- abort in RUN: next cycle IDLE, busy=0, no done, no further step_en; step_en in the abort cycle itself still asserts if phase matched. abort in IDLE ignored; abort and start same IDLE cycle: start wins.
- Inputs coord_sys/n_iter changing during RUN have no effect.
- iter_idx wraps never: width ITER_W+2 covers max step count.

Decomposition:
- Package cordic_seq_pkg: coord_sys_e enum (CIRC, LIN, HYP), function is_hyp_repeat(shift) built from 3k+1 sequence up to 2^ITER_W-1, function hyp_step_count(n_iter).
- Sub-module cordic_step_timer: phase counter with STEP_CYCLES parameter, outputs step_en and window_end; sequencer FSM in top.

Test Plan:
- Circular, STEP_CYCLES=2, n_iter=4, start at cycle 0 -> step_en cycles 1,3,5,7 with shift 0,1,2,3; last in cycles 6-7; done cycle 8; busy cycles 0-7.
- Hyperbolic, n_iter=5 -> shifts 1,2,3,4,4,5 (6 steps); repeat_flag only in second 4 window; last on shift 5; iter_idx=6 at done.
- Hyperbolic, n_iter=13 -> 15 steps, repeats at 4 and 13; final window shift 13 repeat_flag=1, last=1.
- Abort after 2nd step_en of circular n_iter=8 -> busy drops next cycle, no done, no more step_en; new start then runs full 8 steps.
- start held high through run: second start ignored while busy; start during done cycle accepted, busy stays 1 one cycle later with shift reset to 0.
- n_iter=0 -> no busy, no step_en, done pulse next cycle; rst mid-run (STEP_CYCLES=1 build) -> all outputs to reset values next cycle, no done.
